// File: rtl/vector_check_ctrl.sv
// Stimulus sequencer and result checker: exhaustive 2-bit sweep followed by
// LFSR-driven random vectors, with saturating sample/error counters.
module vector_check_ctrl #(
    parameter int unsigned SWEEP_LEN = 9,
    parameter int unsigned RAND_LEN  = 100,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a,
    output logic        b,
    input  logic        q_ref,
    input  logic        q_dut,
    output logic        busy,
    output logic        done,
    output logic        wave_en,
    output logic [15:0] sample_cnt,
    output logic [15:0] err_cnt,
    output logic        err_seen,
    output logic [15:0] first_err
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_RAND, S_DONE} state_t;

    localparam logic [15:0] SWEEP_LAST = 16'(SWEEP_LEN - 1);
    localparam logic [15:0] RAND_LAST  = 16'(RAND_LEN - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cyc;
    logic [15:0] r_lfsr;
    logic [1:0]  r_ab;
    logic [15:0] r_sample;
    logic [15:0] r_err;
    logic        r_seen;
    logic [15:0] r_first;

    logic        w_fb;
    logic [15:0] w_lfsr_next;
    logic        w_active;
    logic        w_mismatch;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
    assign w_fb        = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_lfsr_next = {w_fb, r_lfsr[15:1]};
    assign w_active    = (r_state == S_SWEEP) || (r_state == S_RAND);
    assign w_mismatch  = q_dut ^ q_ref;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)              w_next = S_SWEEP;
            S_SWEEP:        if (r_cyc == SWEEP_LAST) w_next = S_RAND;
            S_RAND:         if (r_cyc == RAND_LAST)  w_next = S_DONE;
            default:                                 w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc    <= '0;
            r_lfsr   <= SEED;
            r_ab     <= '0;
            r_sample <= '0;
            r_err    <= '0;
            r_seen   <= 1'b0;
            r_first  <= '0;
        end else begin
            // Vector on {a,b} during this cycle is checked at the closing edge
            if (w_active) begin
                if (r_sample != 16'hFFFF) r_sample <= r_sample + 16'd1;
                if (w_mismatch) begin
                    if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                    if (!r_seen) begin
                        r_seen  <= 1'b1;
                        r_first <= r_sample;
                    end
                end
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_ab <= '0;
                    if (start) begin
                        r_cyc    <= '0;
                        r_lfsr   <= SEED;
                        r_sample <= '0;
                        r_err    <= '0;
                        r_seen   <= 1'b0;
                        r_first  <= '0;
                    end
                end
                S_SWEEP: begin
                    if (r_cyc == SWEEP_LAST) begin
                        r_cyc <= '0;
                        r_ab  <= r_lfsr[1:0];
                    end else begin
                        r_cyc <= r_cyc + 16'd1;
                        r_ab  <= r_cyc[1:0] + 2'd1;
                    end
                end
                S_RAND: begin
                    r_lfsr <= w_lfsr_next;
                    if (r_cyc == RAND_LAST) begin
                        r_cyc <= '0;
                        r_ab  <= '0;
                    end else begin
                        r_cyc <= r_cyc + 16'd1;
                        r_ab  <= w_lfsr_next[1:0];
                    end
                end
                default: r_ab <= '0;
            endcase
        end
    end

    assign a          = r_ab[1];
    assign b          = r_ab[0];
    assign busy       = w_active;
    assign done       = (r_state == S_DONE);
    assign wave_en    = (r_state == S_SWEEP);
    assign sample_cnt = r_sample;
    assign err_cnt    = r_err;
    assign err_seen   = r_seen;
    assign first_err  = r_first;

endmodule

// File: doc/vector_check_ctrl.md
VECTOR_CHECK_CTRL -- requirements
Module: vector_check_ctrl

Interface
REQ-001 The block SHALL have parameter SWEEP_LEN, default 9, number of exhaustive-sweep vectors (legal range 1..65535).
REQ-002 The block SHALL have parameter RAND_LEN, default 100, number of pseudo-random vectors (legal range 1..65535).
REQ-003 The block SHALL have parameter SEED, default 16'hACE1, LFSR load value (nonzero).
REQ-004 The block SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port start  in  1  run request; sampled in IDLE and DONE only.
REQ-007 The block SHALL have port a  out  1  stimulus bit, MSB of vector {a,b}.
REQ-008 The block SHALL have port b  out  1  stimulus bit, LSB of vector {a,b}.
REQ-009 The block SHALL have port q_ref  in  1  golden-model output for current vector.
REQ-010 The block SHALL have port q_dut  in  1  device-under-test output for current vector.
REQ-011 The block SHALL have port busy  out  1  high in SWEEP or RAND.
REQ-012 The block SHALL have port done  out  1  high in DONE.
REQ-013 The block SHALL have port wave_en  out  1  high in SWEEP only (waveform-capture window).
REQ-014 The block SHALL have port sample_cnt  out  16  vectors checked this run.
REQ-015 The block SHALL have port err_cnt  out  16  mismatching vectors this run.
REQ-016 The block SHALL have port err_seen  out  1  at least one mismatch this run.
REQ-017 The block SHALL have port first_err  out  16  0-based sample index of first mismatch; valid when err_seen=1.

Function
REQ-018 The block SHALL implement states IDLE, SWEEP, RAND, DONE.
REQ-019 IDLE/DONE with start=1 at an edge SHALL go to SWEEP and, in that same edge, clear sample_cnt, err_cnt, err_seen, first_err, sweep index, and reload LFSR with SEED.
REQ-020 start SHALL be ignored in SWEEP and RAND; no restart mid-run.
REQ-021 {a,b} SHALL be registered outputs; in the k-th SWEEP cycle (k=0..SWEEP_LEN-1), {a,b} SHALL equal k mod 4 (0,1,2,3,0,...).
REQ-022 After the SWEEP_LEN-th sweep cycle the block SHALL enter RAND with no idle gap.
REQ-023 The LFSR SHALL be 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, advanced once per RAND cycle; {a,b} SHALL equal lfsr[1:0] of the current state.
REQ-024 After RAND_LEN RAND cycles the block SHALL enter DONE; total run = SWEEP_LEN+RAND_LEN cycles.
REQ-025 In IDLE and DONE, {a,b} SHALL be 2'b00.
REQ-026 q_ref and q_dut SHALL be treated as combinational functions of {a,b} and compared at the rising edge ending each SWEEP/RAND cycle (zero-cycle check latency).
REQ-027 At each such edge sample_cnt SHALL increment; if q_dut != q_ref, err_cnt SHALL increment.
REQ-028 On the first mismatch of a run, first_err SHALL load the pre-increment sample_cnt and err_seen SHALL set; later mismatches SHALL NOT change first_err.
REQ-029 sample_cnt and err_cnt SHALL saturate at 16'hFFFF.
REQ-030 Counters and first_err SHALL hold their values in DONE until the next start.
REQ-031 busy, done and wave_en SHALL be decoded from registered state only (glitch-free).

Reset
REQ-032 rst_n=0 SHALL immediately, asynchronously, force state IDLE, a=b=0, busy=done=wave_en=0, sample_cnt=err_cnt=first_err=0, err_seen=0, LFSR=SEED.
REQ-033 Reset asserted mid-run SHALL abort the run with no completion; after release the block SHALL wait in IDLE for start.
REQ-034 start high on the first edge after reset release SHALL be honoured.

Verification
REQ-035 Defaults, q_dut tied to q_ref, start pulsed -> wave_en high 9 cycles with {a,b}=0,1,2,3,0,1,2,3,0; DONE after 109 cycles; sample_cnt=109, err_cnt=0, err_seen=0.
REQ-036 q_dut=~q_ref always -> err_cnt=109, err_seen=1, first_err=0.
REQ-037 q_dut differs from q_ref only when {a,b}=2'b11 -> first_err=3, err_cnt equals count of 2'b11 vectors (2 in sweep plus LFSR-predicted RAND count).
REQ-038 rst_n low at cycle 50 of a run -> outputs at reset values immediately; new start then runs full 109 cycles with counters from 0.
REQ-039 start held high through run and DONE -> no effect while busy; immediate restart from DONE with counters cleared.
REQ-040 SWEEP_LEN=1, RAND_LEN=1 -> sequence {a,b}=0 then SEED[1:0]; DONE after 2 cycles, sample_cnt=2.
